data_mem_responder: RTL and testbench

Responder side of the core's data-memory port: accepts one load/store request at a time from the CPU over a valid/ready handshake. Performs byte/half/word accesses on an internal word-organised RAM after a fixed, parameterised latency, and returns a response over a second valid/ready handshake. It replaces the single-cycle data memory when the datapath is moved to a stall-capable, multi-cycle memory interface.

---
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder with fixed-latency word RAM and valid/ready handshakes
// Optional DMEM_ALIGN_CHECK_EN: misaligned half/word accesses respond with resp_err and leave RAM untouched.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_next;

  logic [3:0]            count;
  logic                  lat_write, lat_unsigned;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_size;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  accept, access, misaligned;
  logic                  acc_write, acc_unsigned;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [1:0]            acc_size, offset;
  logic [DATA_WIDTH-1:0] acc_wdata, lane_data, cur_word, merged, shifted, load_data;
  logic [3:0]            lanes;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign accept      = (state == IDLE) && req_valid;
  assign access      = (LATENCY == 1) ? accept : (state == WAIT && count == 4'd0);

  // With LATENCY=1 the access happens on the acceptance edge, so it must see the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_write    = req_write;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr[ADDR_WIDTH-1:0];
      acc_size     = req_size;
      acc_wdata    = req_wdata;
    end else begin
      acc_write    = lat_write;
      acc_unsigned = lat_unsigned;
      acc_addr     = lat_addr;
      acc_size     = lat_size;
      acc_wdata    = lat_wdata;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    offset     = acc_addr[1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = (acc_size == 2'b01 && acc_addr[0]) || (acc_size[1] && acc_addr[1:0] != 2'b00);
`else
    if (acc_size[1])
      offset = 2'b00;
    else if (acc_size == 2'b01)
      offset = {acc_addr[1], 1'b0};
`endif
    case (acc_size)
      2'b00: begin
        lanes     = 4'b0001 << offset;
        lane_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        lanes     = 4'b0011 << offset;
        lane_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        lanes     = 4'b1111;
        lane_data = acc_wdata;
      end
    endcase
    cur_word = ram[acc_addr[ADDR_WIDTH-1:2]];
    merged   = cur_word;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    shifted = cur_word >> {offset, 3'b000};
    case (acc_size)
      2'b00:   load_data = acc_unsigned ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = acc_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = cur_word;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (count == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= 4'd0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= 2'b00;
      lat_wdata    <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr[ADDR_WIDTH-1:0];
        lat_size     <= req_size;
        lat_wdata    <= req_wdata;
        count        <= 4'(LATENCY - 1);
      end else if (state == WAIT && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (access) begin
        resp_err   <= misaligned;
        resp_rdata <= (acc_write || misaligned) ? '0 : load_data;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // RAM is deliberately not reset; the rst term keeps a store from committing while reset is held.
  always_ff @(posedge clk) begin
    if (access && acc_write && !misaligned && !rst)
      ram[acc_addr[ADDR_WIDTH-1:2]] <= merged;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder against a byte-array model
// Honours DMEM_ALIGN_CHECK_EN the same way the design does.
module tb_data_mem_responder;
  localparam int LAT = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [7:0] mem8 [4096];
  bit         known [4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [11:0] a, input logic [1:0] s);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a % nbytes(s)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Without alignment checking the address simply rounds down to the access size.
  function automatic int model_base(input logic [11:0] a, input logic [1:0] s);
    return int'(a) - (int'(a) % nbytes(s));
  endfunction

  function automatic logic [31:0] model_load(input logic [11:0] a, input logic [1:0] s, input bit u);
    logic [31:0] v = '0;
    int n = nbytes(s), b = model_base(a, s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem8[b+i];
    if (!u && n < 4 && v[8*n-1])
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit model_known(input logic [11:0] a, input logic [1:0] s);
    bit ok = 1'b1;
    for (int i = 0; i < nbytes(s); i++) ok = ok && known[model_base(a, s)+i];
    return ok;
  endfunction

  task automatic model_store(input logic [11:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) begin
      mem8[model_base(a, s)+i]  = d[8*i +: 8];
      known[model_base(a, s)+i] = 1'b1;
    end
  endtask

  // Compare process: predicts handshake timing and response contents every cycle.
  initial begin
    bit inflight = 1'b0, e_err = 1'b0, e_chk = 1'b0, p_w = 1'b0;
    int due = 0;
    logic [31:0] e_rd = '0, p_d = '0;
    logic [11:0] p_a = '0;
    logic [1:0]  p_s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        inflight = 1'b0;
      end else if (!inflight) begin
        check("idle_req_ready", req_ready, 1);
        check("idle_resp_valid", resp_valid, 0);
        if (req_valid && req_ready) begin
          p_a   = req_addr[11:0];
          p_s   = req_size;
          p_d   = req_wdata;
          e_err = model_mis(p_a, p_s);
          p_w   = req_write && !e_err;
          if (req_write || e_err) begin
            e_rd  = '0;
            e_chk = 1'b1;
          end else begin
            e_rd  = model_load(p_a, p_s, req_unsigned);
            e_chk = model_known(p_a, p_s);
          end
          due      = cyc + 1 + LAT;
          inflight = 1'b1;
        end
      end else begin
        check("busy_req_ready", req_ready, 0);
        if (cyc < due) begin
          check("wait_resp_valid", resp_valid, 0);
        end else begin
          if (cyc == due && p_w) model_store(p_a, p_s, p_d);
          check("resp_valid", resp_valid, 1);
          check("resp_err", resp_err, e_err);
          if (e_chk) check("resp_rdata", resp_rdata, e_rd);
          if (resp_ready) inflight = 1'b0;
        end
      end
    end
  end

  task automatic txn(input bit w, input logic [31:0] a, input logic [1:0] s, input bit u,
                     input logic [31:0] d, input int stall, output logic [31:0] rd, output logic e);
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = d;
    resp_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_addr = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_unsigned = $urandom_range(0, 1); req_wdata = $urandom;
    t = 0;
    @(negedge clk);
    while (!resp_valid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("resp_timeout", resp_valid, 1);
    repeat (stall) @(negedge clk);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    rd = resp_rdata;
    e  = resp_err;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    txn(1, 32'h010, 2'b10, 0, 32'hDEADBEEF, 0, rd, e);
    check("sw_rdata_zero", rd, 32'h0);
    txn(0, 32'h010, 2'b10, 0, 32'h0, 0, rd, e);
    check("lw_010", rd, 32'hDEADBEEF);
    check("lw_010_err", e, 0);

    txn(1, 32'h012, 2'b00, 0, 32'h0000007F, 0, rd, e);
    txn(0, 32'h013, 2'b00, 1, 32'h0, 0, rd, e);
    check("lbu_013", rd, 32'h000000DE);
    txn(0, 32'h013, 2'b00, 0, 32'h0, 0, rd, e);
    check("lb_013", rd, 32'hFFFFFFDE);
    txn(0, 32'h010, 2'b10, 0, 32'h0, 0, rd, e);
    check("lw_010_merged", rd, 32'hDE7FBEEF);
    txn(0, 32'h012, 2'b01, 0, 32'h0, 0, rd, e);
    check("lh_012", rd, 32'hFFFFDE7F);
    txn(0, 32'h010, 2'b01, 1, 32'h0, 0, rd, e);
    check("lhu_010", rd, 32'h0000BEEF);
    check("model_lw_010", model_load(12'h010, 2'b10, 0), 32'hDE7FBEEF);
    check("model_lh_012", model_load(12'h012, 2'b01, 0), 32'hFFFFDE7F);

    txn(0, 32'h010, 2'b10, 0, 32'h0, 5, rd, e);
    check("stall_lw_010", rd, 32'hDE7FBEEF);

    txn(1, 32'h020, 2'b10, 0, 32'h0BADF00D, 0, rd, e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h020; req_size = 2'b10; req_wdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    txn(0, 32'h020, 2'b10, 0, 32'h0, 0, rd, e);
    check("lw_020_after_rst", rd, 32'h0BADF00D);

    txn(1, 32'h021, 2'b10, 0, 32'hAAAAAAAA, 0, rd, e);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_sw_err", e, 1);
    txn(0, 32'h020, 2'b10, 0, 32'h0, 0, rd, e);
    check("lw_020_after_mis", rd, 32'h0BADF00D);
`else
    check("mis_sw_err", e, 0);
    txn(0, 32'h020, 2'b10, 0, 32'h0, 0, rd, e);
    check("lw_020_after_mis", rd, 32'hAAAAAAAA);
`endif

    txn(1, 32'h1004, 2'b00, 0, 32'h00000055, 0, rd, e);
    txn(0, 32'h004, 2'b00, 1, 32'h0, 0, rd, e);
    check("alias_lbu_004", rd, 32'h00000055);

    for (int i = 0; i < 16; i++)
      txn(1, ($urandom & 32'hFFFF_F000) | 32'(i * 4), 2'b10, 0, $urandom, 0, rd, e);
    for (int i = 0; i < 300; i++)
      txn($urandom_range(0, 1), ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
          2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom, $urandom_range(0, 3), rd, e);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
